// File: rtl/fsm_serial_feeder.sv
// Parallel-to-serial feeder for the sequence-detector FSM: accepts words over
// valid/ready, shifts them out one bit per clock on w, with optional idle gaps.
module fsm_serial_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             busy_q, busy_d;
  logic             ready_state;
  logic             accept;
  logic             load;

  // Ready is held low while reset is asserted even though it is decoded from state.
  always_comb begin
    ready_state = 1'b0;
    case (state_q)
      ST_IDLE:  ready_state = 1'b1;
      ST_SHIFT: ready_state = (bit_cnt_q == '0) && (GAP == 0);
      ST_GAP:   ready_state = (gap_cnt_q == 8'd0);
      default:  ready_state = 1'b0;
    endcase
    din_ready = reset & ready_state;
    accept    = din_valid & din_ready;
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    word_count_d = word_count_q;
    load         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) load = 1'b1;
      end
      ST_SHIFT: begin
        shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        bit_cnt_d = bit_cnt_q - BW'(1);
        if (bit_cnt_q == '0) begin
          bit_cnt_d = '0;
          if (word_count_q != {CNT_W{1'b1}}) word_count_d = word_count_q + CNT_W'(1);
          if (GAP > 0) begin
            gap_cnt_d = 8'(GAP - 1);
            state_d   = ST_GAP;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 8'd1;
        if (gap_cnt_q == 8'd0) begin
          gap_cnt_d = 8'd0;
          if (accept) load = 1'b1;
          else        state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
        gap_cnt_d = 8'd0;
      end
    endcase

    if (load) begin
      shift_d   = din;
      bit_cnt_d = BW'(WIDTH - 1);
      state_d   = ST_SHIFT;
    end

    // Outputs are precomputed from next state so they come straight from flops.
    w_valid_d = (state_d == ST_SHIFT);
    busy_d    = (state_d != ST_IDLE);
    w_d       = w_valid_d & (MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= 8'd0;
      word_count_q <= '0;
      w_q          <= 1'b0;
      w_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      word_count_q <= word_count_d;
      w_q          <= w_d;
      w_valid_q    <= w_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign w          = w_q;
  assign w_valid    = w_valid_q;
  assign busy       = busy_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_fsm_serial_feeder.sv
// Directed self-checking bench for fsm_serial_feeder; four instances cover the
// default configuration, GAP=2, LSB-first and a 3-bit saturating word counter.
module tb_fsm_serial_feeder;

  logic clk;
  logic reset;

  logic [7:0]  a_din, g_din, l_din, c_din;
  logic        a_valid, g_valid, l_valid, c_valid;
  logic        a_ready, g_ready, l_ready, c_ready;
  logic        a_w, g_w, l_w, c_w;
  logic        a_wv, g_wv, l_wv, c_wv;
  logic        a_busy, g_busy, l_busy, c_busy;
  logic [15:0] a_cnt, g_cnt, l_cnt;
  logic [2:0]  c_cnt;

  int checks = 0;
  int errors = 0;

  fsm_serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
    .w(a_w), .w_valid(a_wv), .busy(a_busy), .word_count(a_cnt));

  fsm_serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2), .CNT_W(16)) u_gap (
    .clk(clk), .reset(reset), .din(g_din), .din_valid(g_valid), .din_ready(g_ready),
    .w(g_w), .w_valid(g_wv), .busy(g_busy), .word_count(g_cnt));

  fsm_serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0), .CNT_W(16)) u_lsb (
    .clk(clk), .reset(reset), .din(l_din), .din_valid(l_valid), .din_ready(l_ready),
    .w(l_w), .w_valid(l_wv), .busy(l_busy), .word_count(l_cnt));

  fsm_serial_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .CNT_W(3)) u_cnt (
    .clk(clk), .reset(reset), .din(c_din), .din_valid(c_valid), .din_ready(c_ready),
    .w(c_w), .w_valid(c_wv), .busy(c_busy), .word_count(c_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] pat;
    logic [7:0]  b3;
    b3 = 8'b1011_0011;

    reset = 1'b0;
    a_din = 8'h00; g_din = 8'h00; l_din = 8'h00; c_din = 8'h00;
    a_valid = 1'b0; g_valid = 1'b0; l_valid = 1'b0; c_valid = 1'b0;

    // Reset values, then combinational ready once reset releases mid-cycle
    #1;
    check_output("rst_w", a_w, 1'b0);
    check_output("rst_wv", a_wv, 1'b0);
    check_output("rst_busy", a_busy, 1'b0);
    check_output("rst_ready", a_ready, 1'b0);
    check_output("rst_cnt", a_cnt, 16'd0);
    step();
    check_output("rst_ready_edge", a_ready, 1'b0);
    #3 reset = 1'b1;
    #1;
    check_output("ready_after_rst", a_ready, 1'b1);

    // Single MSB-first word 1011_0011
    a_din = b3; a_valid = 1'b1;
    step();
    a_valid = 1'b0; a_din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("w1_bit%0d", i), a_w, b3[7-i]);
      check_output($sformatf("w1_wv%0d", i), a_wv, 1'b1);
      step();
    end
    check_output("w1_idle_wv", a_wv, 1'b0);
    check_output("w1_idle_busy", a_busy, 1'b0);
    check_output("w1_cnt", a_cnt, 16'd1);

    // Back-to-back A5 then 3C with valid held: no bubble, ready only on last bits
    pat = {8'hA5, 8'h3C};
    a_din = 8'hA5; a_valid = 1'b1;
    step();
    a_din = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) a_valid = 1'b0;
      check_output($sformatf("b2b_bit%0d", i), a_w, pat[15-i]);
      check_output($sformatf("b2b_wv%0d", i), a_wv, 1'b1);
      check_output($sformatf("b2b_rdy%0d", i), a_ready, (i == 7 || i == 15));
      step();
    end
    check_output("b2b_idle_wv", a_wv, 1'b0);
    check_output("b2b_cnt", a_cnt, 16'd3);

    // GAP=2: two data words separated by two idle-but-busy cycles
    g_din = 8'hA5; g_valid = 1'b1;
    step();
    g_din = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      logic data_cyc;
      logic exp_w;
      data_cyc = (i < 8) || (i >= 10 && i < 18);
      exp_w = 1'b0;
      if (i < 8) exp_w = pat[15-i];
      else if (i >= 10 && i < 18) exp_w = pat[17-i];
      if (i == 10) g_valid = 1'b0;
      check_output($sformatf("gap_w%0d", i), g_w, exp_w);
      check_output($sformatf("gap_wv%0d", i), g_wv, data_cyc);
      check_output($sformatf("gap_busy%0d", i), g_busy, 1'b1);
      check_output($sformatf("gap_rdy%0d", i), g_ready, (i == 9 || i == 19));
      step();
    end
    check_output("gap_idle_busy", g_busy, 1'b0);
    check_output("gap_cnt", g_cnt, 16'd2);

    // LSB-first 8'h01
    l_din = 8'h01; l_valid = 1'b1;
    step();
    l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("lsb_bit%0d", i), l_w, (i == 0));
      check_output($sformatf("lsb_wv%0d", i), l_wv, 1'b1);
      step();
    end
    check_output("lsb_idle_wv", l_wv, 1'b0);

    // 3-bit counter saturates at 7 over nine continuous words
    c_din = 8'h5A; c_valid = 1'b1;
    step();
    for (int k = 1; k <= 9; k++) begin
      repeat (8) step();
      if (k == 8) c_valid = 1'b0;
      check_output($sformatf("sat_cnt%0d", k), c_cnt, (k < 7) ? k : 7);
    end

    // Fresh reset, then abort a word at bit 4 asynchronously
    reset = 1'b0;
    #2 reset = 1'b1;
    step();
    a_din = b3; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    repeat (4) step();
    check_output("abort_pre_w", a_w, b3[3]);
    check_output("abort_pre_busy", a_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_output("abort_w", a_w, 1'b0);
    check_output("abort_wv", a_wv, 1'b0);
    check_output("abort_busy", a_busy, 1'b0);
    check_output("abort_ready", a_ready, 1'b0);
    check_output("abort_cnt", a_cnt, 16'd0);
    step();
    #3 reset = 1'b1;
    #1;
    a_din = 8'hFF; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("ff_bit%0d", i), a_w, 1'b1);
      check_output($sformatf("ff_wv%0d", i), a_wv, 1'b1);
      step();
    end
    check_output("ff_idle_wv", a_wv, 1'b0);
    check_output("ff_cnt", a_cnt, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_serial_feeder.md
Name: fsm_serial_feeder

Overview:
- Upstream stage of the serial sequence-detector FSM. Converts parallel words, delivered over a valid/ready handshake, into the one-bit-per-clock stream that drives the detector's w input.
- Inserts optional idle gaps between words and keeps a saturating count of words sent.
- Lets the detector be driven from a word source (test-vector memory, CPU register) instead of a hand-fed bit per cycle.

Parameters:
- WIDTH, 8, bits per input word (>=1).
- MSB_FIRST, 1, 1 = din[WIDTH-1] is serialized first; 0 = din[0] is serialized first.
- GAP, 0, idle cycles (w=0, w_valid=0) inserted after each word (0..255).
- CNT_W, 16, width of word_count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word.
- din_ready  output  1  feeder can accept a word this cycle.
- w  output  1  serial bit to the detector FSM.
- w_valid  output  1  w carries a data bit this cycle.
- busy  output  1  a word or its gap is in progress.
- word_count  output  CNT_W  words fully shifted out, saturating.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit counter=0, gap counter=0, w=0, w_valid=0, busy=0, word_count=0, din_ready=0. din_ready rises at the first clock after reset deasserts, or combinationally in IDLE once reset=1.
- Handshake: a word is accepted on a rising edge with din_valid=1 and din_ready=1. din is sampled at that edge only. din_valid may drop or change freely while din_ready=0 (no stall hazard).
- din_ready (combinational from state) is 1 when any of these holds:
  - state=IDLE;
  - state=SHIFT, bit counter=0 and GAP=0;
  - state=GAP and gap counter=0.
- All outputs other than din_ready are functions of registered state only (no input-to-output paths).
- State IDLE: w=0, w_valid=0, busy=0. On accept: load din into shift register, bit counter=WIDTH-1, go to SHIFT.
- State SHIFT: w = serialization end of the shift register (MSB or LSB per MSB_FIRST), w_valid=1, busy=1.
  - Each edge: shift one position toward the serialization end, zero-filled, and decrement the bit counter.
  - At bit counter=0: word_count += 1, saturating at 2^CNT_W-1. Then:
    - GAP>0: gap counter=GAP-1, go to GAP.
    - GAP=0 and accept at the same edge: reload and stay in SHIFT.
    - Otherwise: go to IDLE.
- State GAP: w=0, w_valid=0, busy=1. Decrement the gap counter each edge. At gap counter=0: an accept reloads and goes to SHIFT, otherwise go to IDLE.
- Latency: first bit of a word appears on w the cycle after its accept edge. Each word occupies exactly WIDTH cycles of w_valid=1. With GAP=0 and din_valid held high, w_valid stays 1 continuously with no bubble between words.
- WIDTH=1: every SHIFT cycle is a last-bit cycle; the rules above apply unchanged.
- Reset mid-word or mid-gap: the word is aborted immediately, outputs return to reset values, and the word is not counted.
- Invalid state encodings recover to IDLE.

Test Plan:
- WIDTH=8, MSB_FIRST=1, GAP=0; accept din=8'b1011_0011 at edge N -> w=1,0,1,1,0,0,1,1 with w_valid=1 on cycles N+1..N+8; IDLE at N+9; word_count=1.
- GAP=0, din_valid held high with 8'hA5 then 8'h3C -> 16 consecutive w_valid=1 cycles, w=10100101 00111100; din_ready=1 only in each word's last SHIFT cycle; word_count=2.
- GAP=2, two back-to-back words -> 8 data cycles, 2 cycles of w=0/w_valid=0/busy=1, 8 data cycles; second accept happens on the final gap cycle.
- MSB_FIRST=0, din=8'h01 -> w=1 on the first data cycle, then seven 0s.
- reset driven 0 asynchronously at bit 4 of a word -> w, w_valid and busy go 0 without waiting for a clock edge; word_count unchanged. Release reset, then send 8'hFF -> eight 1s on w; word_count increments by 1.
- CNT_W=3, send 9 words -> word_count reads 1..7 and then holds at 7.
